// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative radix-2 non-restoring divider. An op_start pulse in IDLE or DONE
//   latches the operands. WIDTH iterations follow (one per cycle), then a
//   single FIX cycle restores a negative partial remainder and loads the
//   result registers. A zero divisor completes on the accepting edge itself.
//
//   Optional feature: define DIVIDER_SIGNED_EN for signed two's-complement
//   division. The quotient truncates toward zero and the remainder takes the
//   sign of the dividend. Without the macro the unit divides unsigned values
//   only, and no negation logic is built.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   op_start   in   start request, honoured only in IDLE/DONE
//   dividend   in   WIDTH, sampled on the accepting edge
//   divisor    in   WIDTH, sampled on the accepting edge
//   op_done    out  high in DONE, results valid while high
//   quotient   out  WIDTH, registered quotient
//   remainder  out  WIDTH, registered remainder
//   div_zero   out  high in DONE when the divisor was zero
// -----------------------------------------------------------------------------
module divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             op_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH:0]   p_r;        // partial remainder, extra bit keeps the sign
  logic [WIDTH-1:0] q_r;        // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_r;        // divisor magnitude
  logic             op_done_r;
  logic             div_zero_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic             accept_s;
  logic             zero_div_s;
  logic [WIDTH-1:0] dvd_mag_s;
  logic [WIDTH-1:0] dvs_mag_s;
  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH:0]   p_step_s;
  logic [WIDTH-1:0] r_mag_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg_r;   // operand signs differ: negate quotient
  logic r_neg_r;   // dividend negative: negate remainder

  function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
    neg_val = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      abs_val = neg_val(v);
    end else begin
      abs_val = v;
    end
  endfunction
`endif

  assign accept_s   = op_start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign zero_div_s = (divisor == ZERO_W);

  // Operand magnitudes and the per-iteration / fix-up datapath.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_mag_s = abs_val(dividend);
    dvs_mag_s = abs_val(divisor);
`else
    dvd_mag_s = dividend;
    dvs_mag_s = divisor;
`endif
    // The add/subtract choice uses the sign of P before the shift; modulo
    // 2^(WIDTH+1) arithmetic keeps the result in range even if 2P overflows.
    p_shift_s = {p_r[WIDTH-1:0], q_r[WIDTH-1]};
    if (p_r[WIDTH]) begin
      p_step_s = p_shift_s + {1'b0, d_r};
    end else begin
      p_step_s = p_shift_s - {1'b0, d_r};
    end
    // The restored remainder lies in [0, D), so WIDTH-bit arithmetic is exact.
    if (p_r[WIDTH]) begin
      r_mag_s = p_r[WIDTH-1:0] + d_r;
    end else begin
      r_mag_s = p_r[WIDTH-1:0];
    end
`ifdef DIVIDER_SIGNED_EN
    if (q_neg_r) begin
      q_fix_s = neg_val(q_r);
    end else begin
      q_fix_s = q_r;
    end
    if (r_neg_r) begin
      r_fix_s = neg_val(r_mag_s);
    end else begin
      r_fix_s = r_mag_s;
    end
`else
    q_fix_s = q_r;
    r_fix_s = r_mag_s;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (op_start) begin
          if (zero_div_s) begin
            state_next_s = S_DONE;
          end else begin
            state_next_s = S_CALC;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      S_CALC: begin
        if (count_r == LAST_CNT) begin
          state_next_s = S_FIX;
        end else begin
          state_next_s = S_CALC;
        end
      end
      S_FIX:   state_next_s = S_DONE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r     <= {CW{1'b0}};
      p_r         <= {(WIDTH+1){1'b0}};
      q_r         <= ZERO_W;
      d_r         <= ZERO_W;
      op_done_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      quotient_r  <= ZERO_W;
      remainder_r <= ZERO_W;
`ifdef DIVIDER_SIGNED_EN
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            count_r    <= {CW{1'b0}};
            p_r        <= {(WIDTH+1){1'b0}};
            q_r        <= dvd_mag_s;
            d_r        <= dvs_mag_s;
            op_done_r  <= 1'b0;
            div_zero_r <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            q_neg_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r    <= dividend[WIDTH-1];
`endif
            if (zero_div_s) begin
              quotient_r  <= ONES_W;
              remainder_r <= dividend;
              div_zero_r  <= 1'b1;
              op_done_r   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          p_r     <= p_step_s;
          q_r     <= {q_r[WIDTH-2:0], ~p_step_s[WIDTH]};
          count_r <= count_r + CNT_ONE;
        end
        S_FIX: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
          op_done_r   <= 1'b1;
        end
        default: begin
          op_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign op_done   = op_done_r;
  assign div_zero  = div_zero_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider. A transaction-level reference (native
//   division operators plus a per-operation latency counter) predicts every
//   output on every cycle; directed vectors add literal expectations.
// -----------------------------------------------------------------------------
module tb_divider;

  logic        clk;
  logic        reset;
  logic        op_start;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        op_done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  divider #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_start  (op_start),
    .dividend  (dividend),
    .divisor   (divisor),
    .op_done   (op_done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference quotient/remainder, packed as {q, r}.
  function automatic logic [127:0] ref_div(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q;
    logic [63:0] r;
`ifdef DIVIDER_SIGNED_EN
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = a;
    sb = b;
    if (a == MINV && b == ALL1) begin
      q = MINV;
      r = 64'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
`else
    q = a / b;
    r = a % b;
`endif
    return {q, r};
  endfunction

  // Model state: outputs plus cycles remaining until the pending result lands.
  logic         m_done = 1'b0;
  logic         m_dz   = 1'b0;
  logic [63:0]  m_q    = 64'd0;
  logic [63:0]  m_r    = 64'd0;
  logic [127:0] m_pend = 128'd0;
  int           m_left = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= 64'd0;
      m_r    <= 64'd0;
      m_left <= 0;
    end else if (m_left == 0) begin
      if (op_start) begin
        m_dz   <= 1'b0;
        m_done <= 1'b0;
        if (divisor == 64'd0) begin
          m_q    <= ALL1;
          m_r    <= dividend;
          m_dz   <= 1'b1;
          m_done <= 1'b1;
        end else begin
          m_pend <= ref_div(dividend, divisor);
          m_left <= 65;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_q    <= m_pend[127:64];
        m_r    <= m_pend[63:0];
        m_done <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("cyc_op_done", {63'd0, op_done}, {63'd0, m_done});
    check("cyc_div_zero", {63'd0, div_zero}, {63'd0, m_dz});
    check("cyc_quotient", quotient, m_q);
    check("cyc_remainder", remainder, m_r);
  end

  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk); #1;
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    @(negedge clk); #1;
    op_start = 1'b0;
  endtask

  // Counts edges after the accepting edge until op_done is seen (bounded).
  task automatic wait_done(output int k);
    k = 0;
    while (!op_done && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic run(input string name, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] eq, input logic [63:0] er,
                     input logic edz, input int ek);
    int k;
    start_op(a, b);
    if (!edz) check({name, "_done_low"}, {63'd0, op_done}, 64'd0);
    wait_done(k);
    check({name, "_latency"}, 64'(k), 64'(ek));
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dz"}, {63'd0, div_zero}, {63'd0, edz});
  endtask

  initial begin
    int k;
    reset    = 1'b1;
    op_start = 1'b0;
    dividend = 64'd0;
    divisor  = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_done", {63'd0, op_done}, 64'd0);
    check("rst_q", quotient, 64'd0);
    check("rst_r", remainder, 64'd0);
    check("rst_dz", {63'd0, div_zero}, 64'd0);
    reset = 1'b0;

    run("u100_7",  64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);
    run("dz1234",  64'h1234, 64'd0, ALL1, 64'h1234, 1'b1, 0);
    run("max_1",   ALL1, 64'd1, ALL1, 64'd0, 1'b0, 65);
    run("u5_9",    64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65);

    // Reset in the middle of CALC discards everything.
    start_op(64'd100, 64'd7);
    repeat (29) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_done", {63'd0, op_done}, 64'd0);
    check("midrst_q", quotient, 64'd0);
    check("midrst_r", remainder, 64'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    run("after_rst", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);

    // op_start during CALC is ignored.
    start_op(64'd100, 64'd7);
    repeat (10) @(negedge clk);
    #1;
    dividend = 64'd3;
    divisor  = 64'd1;
    op_start = 1'b1;
    @(negedge clk); #1;
    op_start = 1'b0;
    wait_done(k);
    check("ign_q", quotient, 64'd14);
    check("ign_r", remainder, 64'd2);

    // New operation straight from DONE.
    run("done_50_5", 64'd50, 64'd5, 64'd10, 64'd0, 1'b0, 65);

    // op_start held high: back-to-back restarts from DONE.
    @(negedge clk); #1;
    dividend = 64'd9;
    divisor  = 64'd3;
    op_start = 1'b1;
    repeat (140) @(negedge clk);
    #1;
    op_start = 1'b0;
    wait_done(k);
    check("b2b_q", quotient, 64'd3);
    check("b2b_r", remainder, 64'd0);

`ifdef DIVIDER_SIGNED_EN
    run("s_m7_2",  -64'sd7, 64'd2, -64'sd3, -64'sd1, 1'b0, 65);
    run("s_7_m2",  64'd7, -64'sd2, -64'sd3, 64'd1, 1'b0, 65);
    run("s_min_m1", MINV, ALL1, MINV, 64'd0, 1'b0, 65);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
